// File: rtl/shift_pkg.sv
// shift_pkg: state and direction encodings shared by the shift sequencer and its step stage.
package shift_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam logic SHIFT_RIGHT = 1'b1;
    localparam logic SHIFT_LEFT  = 1'b0;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational shift or rotate of DATA_WIDTH bits by 0..STEP_BITS positions.
module shift_step
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STEP_BITS  = 2,
    parameter int SW         = $clog2(STEP_BITS + 1)
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [SW-1:0]         amount,
    input  logic                  dir,
    input  logic                  wrap,
    output logic [DATA_WIDTH-1:0] result
);
    logic [2*DATA_WIDTH-1:0] dbl, rot_r, rot_l;
    // Rotation reads the wanted window out of the operand concatenated with itself.
    always_comb begin
        dbl    = {data, data};
        rot_r  = dbl >> amount;
        rot_l  = dbl << amount;
        result = wrap ? ((dir == SHIFT_RIGHT) ? rot_r[DATA_WIDTH-1:0] : rot_l[2*DATA_WIDTH-1:DATA_WIDTH])
                      : ((dir == SHIFT_RIGHT) ? data >> amount : data << amount);
    end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: variable-amount shifter that iterates a fixed-width shift stage once per clock
// between a valid/ready request port and a valid/ready result port.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter BLOCK_NAME       = "shift_sequencer",
    parameter int X            = 0,
    parameter int Y            = 0,
    parameter int DX           = 0,
    parameter int DY           = 0,
    parameter ARCHITECTURE     = "BEHAVIORAL",
    parameter int DATA_WIDTH   = 8,
    parameter int AMOUNT_WIDTH = 4,
    parameter int STEP_BITS    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [AMOUNT_WIDTH-1:0] in_amount,
    input  logic                    in_dir,
    input  logic                    in_wrap,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    busy
);
    localparam int SW = $clog2(STEP_BITS + 1);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   data_q, step_result;
    logic [AMOUNT_WIDTH-1:0] remaining;
    logic                    dir_q, wrap_q;
    logic [SW-1:0]           step;

    always_comb step = (32'(remaining) < STEP_BITS) ? SW'(remaining) : SW'(STEP_BITS);

    // Vendor-specific variants are placeholders; only the behavioural stage is implemented.
    if (ARCHITECTURE == "BEHAVIORAL") begin : g_behav
        shift_step #(.DATA_WIDTH(DATA_WIDTH), .STEP_BITS(STEP_BITS), .SW(SW)) u_step (
            .data   (data_q),
            .amount (step),
            .dir    (dir_q),
            .wrap   (wrap_q),
            .result (step_result)
        );
    end else begin : g_vendor
        assign step_result = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            remaining <= '0;
            data_q    <= '0;
            dir_q     <= SHIFT_LEFT;
            wrap_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    data_q    <= in_data;
                    remaining <= in_amount;
                    dir_q     <= in_dir;
                    wrap_q    <= in_wrap;
                    in_ready  <= 1'b0;
                    busy      <= 1'b1;
                    if (in_amount == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    data_q    <= step_result;
                    remaining <= remaining - AMOUNT_WIDTH'(step);
                    if (32'(remaining) == 32'(step)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= step_result;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed and randomized requests checked against an index-arithmetic reference model.
module tb_shift_sequencer;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, in_dir = 1'b0, in_wrap = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic [3:0] in_amount = '0;
    logic       in_ready, out_valid, busy;
    logic [7:0] out_data;
    int         passed = 0, total = 0;

    shift_sequencer #(.DATA_WIDTH(8), .AMOUNT_WIDTH(4), .STEP_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amount(in_amount), .in_dir(in_dir), .in_wrap(in_wrap),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Each result bit is looked up directly from its source position in the operand.
    function automatic logic [7:0] model(input logic [7:0] d, input int a, input logic dr, input logic w);
        logic [7:0] r;
        int k;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (w) begin
                k = a % 8;
                r[i] = dr ? d[(i + k) % 8] : d[(i + 8 - k) % 8];
            end else begin
                if (dr && i + a < 8) r[i] = d[i + a];
                if (!dr && i - a >= 0) r[i] = d[i - a];
            end
        end
        return r;
    endfunction

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic do_req(input logic [7:0] d, input int a, input logic dr, input logic w, input int hold);
        int lat;
        logic [7:0] exp;
        exp = model(d, a, dr, w);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_data = d; in_amount = 4'(a); in_dir = dr; in_wrap = w;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'($urandom); in_amount = 4'($urandom); in_dir = 1'($urandom); in_wrap = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 1 + (a + 1) / 2);
        check("out_data", out_data, exp);
        check("in_ready_busy", in_ready, 0);
        check("busy_done", busy, 1);
        repeat (hold) begin
            in_valid = 1'b1; in_data = 8'($urandom); in_amount = 4'($urandom);
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, exp);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drop_valid", out_valid, 0);
        check("back_idle", in_ready, 1);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(8'hB4, 3, 1'b1, 1'b0, 0);
        check("plan_b4", out_data, 8'h16);
        do_req(8'h81, 1, 1'b0, 1'b1, 0);
        check("plan_rotl", out_data, 8'h03);
        do_req(8'h81, 1, 1'b0, 1'b0, 0);
        check("plan_shl", out_data, 8'h02);
        do_req(8'h5A, 0, 1'b1, 1'b0, 0);
        check("plan_zero", out_data, 8'h5A);
        do_req(8'hFF, 9, 1'b0, 1'b0, 0);
        check("plan_over_shl", out_data, 8'h00);
        do_req(8'h01, 9, 1'b1, 1'b1, 0);
        check("plan_over_rotr", out_data, 8'h80);
        do_req(8'hC3, 5, 1'b1, 1'b1, 5);
        // Abort a long operation with an asynchronous reset between clock edges.
        in_valid = 1'b1; in_data = 8'h37; in_amount = 4'd9; in_dir = 1'b1; in_wrap = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_out_data", out_data, 0);
        check("arst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(8'h37, 9, 1'b1, 1'b1, 0);
        for (int n = 0; n < 40; n++)
            do_req(8'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Iterative variable-amount shift controller built around a fixed-step shift stage. It accepts one request (data, amount, direction, wrap) over a valid/ready handshake. It then applies STEP_BITS-wide shifts, one per clock, until the requested amount is consumed, and presents the result on a valid/ready output. It sits between a configuration/datapath requester and downstream consumers wherever a variable shift is needed without the area of a full barrel shifter.

Parameters:
BLOCK_NAME, "shift_sequencer", hierarchical block name for diagram positioning
X, 0, x location within sub-block
Y, 0, y location within sub-block
DX, 0, x length
DY, 0, y length
ARCHITECTURE, "BEHAVIORAL", BEHAVIORAL only; VIRTEX5/VIRTEX6 branches present but empty
DATA_WIDTH, 8, data bits
AMOUNT_WIDTH, 4, width of requested shift amount
STEP_BITS, 2, max bits shifted per cycle; 1 <= STEP_BITS <= DATA_WIDTH

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept request
in_data  input  DATA_WIDTH  operand
in_amount  input  AMOUNT_WIDTH  total bits to shift
in_dir  input  1  1 = shift right, 0 = shift left
in_wrap  input  1  1 = rotate, 0 = zero fill
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  DATA_WIDTH  shifted result
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; in_ready=1; out_valid=0; busy=0; out_data=0; internal remaining=0. Reset asserted mid-SHIFT or mid-DONE aborts immediately; the pending result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On an edge with in_valid: capture data, amount, dir and wrap. Go to SHIFT if in_amount != 0; go to DONE with out_data=in_data if in_amount == 0.
- SHIFT: in_ready=0, busy=1. Each edge: step = min(STEP_BITS, remaining); data shifted by step in the captured direction; remaining -= step. When remaining reaches 0 on that edge, go to DONE.
- Shift semantics per step: wrap=0 zero-fills vacated bits; wrap=1 rotates. The amount is not reduced modulo DATA_WIDTH.
  - Non-wrap with amount >= DATA_WIDTH yields 0.
  - Wrap yields rotation by amount mod DATA_WIDTH, which falls out naturally from iteration.
- DONE: out_valid=1; out_data held stable. On an edge with out_ready, go to IDLE and drop out_valid. in_ready stays 0 until IDLE is reached, so there is no overlap of an output handshake and a new accept.
- Latency: out_valid rises after 1 + ceil(amount/STEP_BITS) edges from the accept edge (1 edge for amount 0).
- Throughput: one request per (latency + 1) cycles minimum.
- in_valid is ignored outside IDLE. Requester inputs are only sampled at the accept edge and may change afterwards.
- out_ready is ignored outside DONE.

Decomposition:
- Shared package shift_pkg: state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and direction constants (SHIFT_RIGHT=1, SHIFT_LEFT=0).
- One sub-module, shift_step: combinational shift/rotate of DATA_WIDTH bits by a 0..STEP_BITS amount with dir and wrap inputs. It is instantiated once; the FSM and registers live in shift_sequencer.

Test Plan:
All scenarios use DATA_WIDTH=8, STEP_BITS=2, AMOUNT_WIDTH=4.
- Right, no wrap: in_data=0xB4, amount=3, dir=1, wrap=0 -> out_data=0x16; out_valid 3 edges after accept; steps 2 then 1.
- Left, wrap: 0x81, amount=1, dir=0, wrap=1 -> 0x03 after 2 edges. Same data with wrap=0 -> 0x02.
- Zero amount: 0x5A, amount=0 -> 0x5A, out_valid 1 edge after accept, SHIFT never entered.
- Over-range: 0xFF, amount=9, left, wrap=0 -> 0x00. Then 0x01, amount=9, right, wrap=1 -> 0x80. Each has out_valid after 6 edges.
- Backpressure and holding: out_ready low for 5 cycles in DONE -> out_data and out_valid stable, in_ready=0, in_valid pulses ignored. out_ready high -> IDLE next edge, in_ready=1.
- Reset mid-operation: assert rst_n=0 during SHIFT of amount=9 -> out_valid=0, in_ready=1, out_data=0 without waiting for clk. After release, a new request completes correctly.
